// File: rtl/sd_dat_responder.sv
// SD card-side DAT[3:0] engine: streams one 512-byte block to the host on read,
// receives one block with per-line CRC16 check on write, then answers with token and busy.
module sd_dat_responder #(
  parameter int NAC         = 2,
  parameter int NCRC        = 2,
  parameter int BUSY_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdclk,
  input  logic [3:0] sddat_in,
  output logic [3:0] sddat_out,
  output logic       sddat_oe,
  input  logic       rd_start,
  input  logic       wr_start,
  output logic       busy,
  output logic       done,
  output logic       crc_err,
  output logic [8:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_we
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD_NAC   = 4'd1,
    RD_DATA  = 4'd2,
    RD_CRC   = 4'd3,
    RD_END   = 4'd4,
    WR_WAIT  = 4'd5,
    WR_DATA  = 4'd6,
    WR_CRC   = 4'd7,
    WR_END   = 4'd8,
    WR_NCRC  = 4'd9,
    WR_TOKEN = 4'd10,
    WR_BUSY  = 4'd11,
    WR_REL   = 4'd12
  } state_t;

  localparam logic [10:0] NAC_CNT   = 11'(NAC);
  localparam logic [10:0] NCRC_LAST = 11'(NCRC - 1);
  localparam logic [10:0] BUSY_CNT  = 11'(BUSY_CYCLES);

  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic b);
    logic c;
    c = crc_in[15] ^ b;
    return {crc_in[14:0], c} ^ {3'b000, c, 6'b000000, c, 5'b00000};
  endfunction

  state_t           state, state_nxt;
  logic [10:0]      cnt, cnt_nxt;
  logic [3:0][15:0] crc, crc_nxt;
  logic [3:0][15:0] rx_crc, rx_crc_nxt;
  logic [3:0]       hi_nib, hi_nib_nxt;
  logic [3:0]       out_nxt;
  logic [3:0]       rd_nib;
  logic [4:0]       token;
  logic             tok_bit;
  logic             oe_nxt, we_nxt, done_nxt, err_nxt;
  logic [8:0]       addr_nxt;
  logic [7:0]       wdata_nxt;
  logic             prev, rise, fall;

  assign rise   = ~prev & sdclk;
  assign fall   = prev & ~sdclk;
  assign rd_nib = cnt[0] ? mem_rdata[3:0] : mem_rdata[7:4];
  assign token  = crc_err ? 5'b01011 : 5'b00101;

  // Next-state and next-output decode; every register holds unless its event fires.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    crc_nxt    = crc;
    rx_crc_nxt = rx_crc;
    hi_nib_nxt = hi_nib;
    out_nxt    = sddat_out;
    oe_nxt     = sddat_oe;
    we_nxt     = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = crc_err;
    wdata_nxt  = mem_wdata;
    tok_bit    = 1'b1;
    // Address steps after each write strobe, saturating at the last byte.
    if (mem_we && (mem_addr != 9'd511)) addr_nxt = mem_addr + 9'd1;
    else                                addr_nxt = mem_addr;

    case (cnt[2:0])
      3'd0:    tok_bit = token[4];
      3'd1:    tok_bit = token[3];
      3'd2:    tok_bit = token[2];
      3'd3:    tok_bit = token[1];
      3'd4:    tok_bit = token[0];
      default: tok_bit = 1'b1;
    endcase

    case (state)
      IDLE: begin
        oe_nxt  = 1'b0;
        out_nxt = 4'hF;
        if (rd_start) begin
          state_nxt = RD_NAC;
          addr_nxt  = 9'd0;
          oe_nxt    = 1'b1;
          cnt_nxt   = 11'd0;
        end else if (wr_start) begin
          state_nxt = WR_WAIT;
          err_nxt   = 1'b0;
          cnt_nxt   = 11'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD_NAC: begin
        if (fall && (cnt == NAC_CNT)) begin
          out_nxt   = 4'h0;
          crc_nxt   = '0;
          cnt_nxt   = 11'd0;
          state_nxt = RD_DATA;
        end else if (fall) begin
          cnt_nxt = cnt + 11'd1;
        end else begin
          cnt_nxt = cnt;
        end
      end
      RD_DATA: begin
        if (fall) begin
          out_nxt = rd_nib;
          for (int i = 0; i < 4; i++) crc_nxt[i] = crc16_step(crc[i], rd_nib[i]);
          // Prefetch: next byte settles on mem_rdata before the following even fall.
          if (cnt[0] && (mem_addr != 9'd511)) addr_nxt = mem_addr + 9'd1;
          else                                addr_nxt = mem_addr;
          if (cnt == 11'd1023) begin
            state_nxt = RD_CRC;
            cnt_nxt   = 11'd0;
          end else begin
            cnt_nxt = cnt + 11'd1;
          end
        end else begin
          cnt_nxt = cnt;
        end
      end
      RD_CRC: begin
        if (fall) begin
          for (int i = 0; i < 4; i++) begin
            out_nxt[i] = crc[i][15];
            crc_nxt[i] = {crc[i][14:0], 1'b0};
          end
          if (cnt == 11'd15) begin
            state_nxt = RD_END;
            cnt_nxt   = 11'd0;
          end else begin
            cnt_nxt = cnt + 11'd1;
          end
        end else begin
          cnt_nxt = cnt;
        end
      end
      RD_END: begin
        if (fall && (cnt == 11'd0)) begin
          out_nxt = 4'hF;
          cnt_nxt = 11'd1;
        end else if (fall) begin
          oe_nxt    = 1'b0;
          done_nxt  = 1'b1;
          cnt_nxt   = 11'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt;
        end
      end
      WR_WAIT: begin
        oe_nxt = 1'b0;
        if (rise && !sddat_in[0]) begin
          state_nxt = WR_DATA;
          crc_nxt   = '0;
          addr_nxt  = 9'd0;
          cnt_nxt   = 11'd0;
        end else begin
          state_nxt = WR_WAIT;
        end
      end
      WR_DATA: begin
        if (rise) begin
          for (int i = 0; i < 4; i++) crc_nxt[i] = crc16_step(crc[i], sddat_in[i]);
          if (cnt[0]) begin
            wdata_nxt = {hi_nib, sddat_in};
            we_nxt    = 1'b1;
          end else begin
            hi_nib_nxt = sddat_in;
          end
          if (cnt == 11'd1023) begin
            state_nxt = WR_CRC;
            cnt_nxt   = 11'd0;
          end else begin
            cnt_nxt = cnt + 11'd1;
          end
        end else begin
          cnt_nxt = cnt;
        end
      end
      WR_CRC: begin
        if (rise) begin
          for (int i = 0; i < 4; i++) rx_crc_nxt[i] = {rx_crc[i][14:0], sddat_in[i]};
          if (cnt == 11'd15) begin
            state_nxt = WR_END;
            cnt_nxt   = 11'd0;
          end else begin
            cnt_nxt = cnt + 11'd1;
          end
        end else begin
          cnt_nxt = cnt;
        end
      end
      WR_END: begin
        if (rise) begin
          err_nxt   = (rx_crc != crc) || (sddat_in != 4'hF);
          state_nxt = WR_NCRC;
          cnt_nxt   = 11'd0;
        end else begin
          state_nxt = WR_END;
        end
      end
      WR_NCRC: begin
        if (fall) begin
          oe_nxt  = 1'b1;
          out_nxt = 4'hF;
          if (cnt == NCRC_LAST) begin
            state_nxt = WR_TOKEN;
            cnt_nxt   = 11'd0;
          end else begin
            cnt_nxt = cnt + 11'd1;
          end
        end else begin
          cnt_nxt = cnt;
        end
      end
      WR_TOKEN: begin
        if (fall) begin
          out_nxt = {3'b111, tok_bit};
          if (cnt == 11'd4) begin
            state_nxt = WR_BUSY;
            cnt_nxt   = 11'd0;
          end else begin
            cnt_nxt = cnt + 11'd1;
          end
        end else begin
          cnt_nxt = cnt;
        end
      end
      WR_BUSY: begin
        if (fall && (cnt == BUSY_CNT)) begin
          out_nxt   = 4'hF;
          state_nxt = WR_REL;
          cnt_nxt   = 11'd0;
        end else if (fall) begin
          out_nxt = 4'hE;
          cnt_nxt = cnt + 11'd1;
        end else begin
          cnt_nxt = cnt;
        end
      end
      WR_REL: begin
        if (fall) begin
          oe_nxt    = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WR_REL;
        end
      end
      default: begin
        state_nxt = IDLE;
        oe_nxt    = 1'b0;
        out_nxt   = 4'hF;
      end
    endcase
  end

  // State and output registers; sdclk history tracks even in reset so no edge is seen on release.
  always_ff @(posedge clk) begin
    prev <= sdclk;
    if (rst) begin
      state     <= IDLE;
      cnt       <= 11'd0;
      crc       <= '0;
      rx_crc    <= '0;
      hi_nib    <= 4'h0;
      sddat_out <= 4'hF;
      sddat_oe  <= 1'b0;
      mem_addr  <= 9'd0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      done      <= 1'b0;
      busy      <= 1'b0;
      crc_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      crc       <= crc_nxt;
      rx_crc    <= rx_crc_nxt;
      hi_nib    <= hi_nib_nxt;
      sddat_out <= out_nxt;
      sddat_oe  <= oe_nxt;
      mem_addr  <= addr_nxt;
      mem_we    <= we_nxt;
      mem_wdata <= wdata_nxt;
      done      <= done_nxt;
      busy      <= (state_nxt != IDLE);
      crc_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sd_dat_responder.sv
// Host-side bench for sd_dat_responder: random sectors, reference CRC16 per line,
// token/busy timing, start collisions and mid-transfer resets.
module tb_sd_dat_responder;
  localparam int NAC = 2, NCRC = 2, BUSY_CYCLES = 8;

  logic       clk = 1'b0, rst = 1'b1;
  logic       sdclk;
  logic [1:0] div = 2'd0;
  logic [3:0] sddat_in = 4'hF, sddat_out;
  logic       sddat_oe, rd_start = 1'b0, wr_start = 1'b0;
  logic       busy, done, crc_err, mem_we;
  logic [8:0] mem_addr;
  logic [7:0] mem_rdata, mem_wdata;

  logic [7:0]  mem [512];
  logic [7:0]  ref_mem [512];
  logic [7:0]  wr_buf [512];
  logic        load_en = 1'b0;
  logic [16:0] we_q [$];
  int          done_cnt = 0;
  int          n_cmp = 0, n_bad = 0;

  sd_dat_responder #(.NAC(NAC), .NCRC(NCRC), .BUSY_CYCLES(BUSY_CYCLES)) dut (
    .clk(clk), .rst(rst), .sdclk(sdclk), .sddat_in(sddat_in), .sddat_out(sddat_out),
    .sddat_oe(sddat_oe), .rd_start(rd_start), .wr_start(wr_start), .busy(busy),
    .done(done), .crc_err(crc_err), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  always #5 clk = ~clk;
  // sdclk = clk/4, changing on the falling clk edge
  always @(negedge clk) div <= div + 2'd1;
  assign sdclk = div[1];

  // Sector buffer: bulk load from the bench, byte writes from the DUT, 1-clk read latency.
  always @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < 512; k++) mem[k] <= ref_mem[k];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Done pulses and write strobes observed between clock edges.
  always @(negedge clk) begin
    if (done) done_cnt = done_cnt + 1;
    if (mem_we) we_q.push_back({mem_addr, mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Textbook MSB-first CCITT CRC over one line's bit stream (high nibble bit, then low).
  function automatic logic [15:0] ref_crc(input logic [7:0] data [512], input int line);
    logic [15:0] r;
    logic        b, fb;
    r = 16'h0000;
    for (int k = 0; k < 512; k++) begin
      for (int h = 0; h < 2; h++) begin
        b  = (h == 0) ? data[k][4 + line] : data[k][line];
        fb = r[15] ^ b;
        r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return r;
  endfunction

  task automatic load(input bit incr);
    logic [7:0] v;
    for (int k = 0; k < 512; k++) begin
      v = 8'($urandom);
      ref_mem[k] = incr ? k[7:0] : v;
    end
    @(negedge clk); load_en = 1'b1;
    @(negedge clk); load_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic read_block(input int abort_at, input bit with_wr);
    int          nf, d0;
    bit          got;
    logic [3:0]  hi;
    logic [15:0] rx [4];
    nf = 0; got = 1'b0; d0 = done_cnt; hi = 4'h0;
    for (int i = 0; i < 4; i++) rx[i] = 16'h0000;
    @(posedge sdclk); rd_start = 1'b1; wr_start = with_wr;
    @(negedge clk);   rd_start = 1'b0; wr_start = 1'b0;
    check("rd_busy", busy, 1);
    for (int n = 0; n < 64 && !got; n++) begin
      @(posedge sdclk);
      if (sddat_oe && sddat_out == 4'h0) got = 1'b1;
      else if (sddat_oe && sddat_out == 4'hF) nf++;
    end
    check("rd_start_bit", got, 1);
    check("rd_nac_len", nf, NAC);
    if (!got) return;
    for (int n = 0; n < 1024; n++) begin
      @(posedge sdclk);
      if (n == abort_at) begin
        do_reset();
        check("rst_rd_oe", sddat_oe, 0);
        check("rst_rd_busy", busy, 0);
        check("rst_rd_addr", mem_addr, 0);
        check("rst_rd_out", sddat_out, 4'hF);
        return;
      end
      if (n % 2 == 0) hi = sddat_out;
      else check("rd_byte", {hi, sddat_out}, ref_mem[n / 2]);
    end
    for (int k = 0; k < 16; k++) begin
      @(posedge sdclk);
      for (int i = 0; i < 4; i++) rx[i] = {rx[i][14:0], sddat_out[i]};
    end
    for (int i = 0; i < 4; i++) check("rd_crc_line", rx[i], ref_crc(ref_mem, i));
    @(posedge sdclk); check("rd_end_bit", {sddat_oe, sddat_out}, 5'h1F);
    @(posedge sdclk); check("rd_oe_off", sddat_oe, 0);
    check("rd_done_once", done_cnt - d0, 1);
    check("rd_idle", busy, 0);
  endtask

  task automatic write_block(input int flip_line, input logic [3:0] end_nib,
                             input bit rd_inject, input bit abort_busy);
    logic [15:0] tx [4];
    logic [4:0]  tok;
    bit          err;
    int          d0, wb, pos;
    for (int i = 0; i < 4; i++) tx[i] = ref_crc(wr_buf, i);
    if (flip_line >= 0) begin
      pos = $urandom_range(0, 15);
      tx[flip_line] = tx[flip_line] ^ (16'h0001 << pos);
    end
    err = (flip_line >= 0) || (end_nib != 4'hF);
    tok = err ? 5'b01011 : 5'b00101;
    d0 = done_cnt; wb = we_q.size();
    @(posedge sdclk); wr_start = 1'b1;
    @(negedge clk);   wr_start = 1'b0;
    @(negedge sdclk); sddat_in = 4'h0;
    for (int k = 0; k < 512; k++) begin
      @(negedge sdclk); sddat_in = wr_buf[k][7:4];
      @(negedge sdclk); sddat_in = wr_buf[k][3:0];
      if (rd_inject && k == 200) begin
        @(negedge clk); rd_start = 1'b1;
        @(negedge clk); rd_start = 1'b0;
      end
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge sdclk);
      for (int i = 0; i < 4; i++) sddat_in[i] = tx[i][15 - k];
    end
    @(negedge sdclk); sddat_in = end_nib;
    @(posedge sdclk);
    @(negedge sdclk); sddat_in = 4'hF;
    check("wr_we_count", we_q.size() - wb, 512);
    if (we_q.size() - wb == 512)
      for (int k = 0; k < 512; k++) check("wr_we_addr_data", we_q[wb + k], {k[8:0], wr_buf[k]});
    for (int k = 0; k < 512; k++) ref_mem[k] = wr_buf[k];
    for (int j = 0; j < NCRC; j++) begin
      @(posedge sdclk); check("wr_ncrc_high", {sddat_oe, sddat_out}, 5'h1F);
    end
    check("wr_crc_err", crc_err, err);
    for (int j = 0; j < 5; j++) begin
      @(posedge sdclk); check("wr_token", {sddat_oe, sddat_out}, {1'b1, 3'b111, tok[4 - j]});
    end
    for (int j = 0; j < BUSY_CYCLES; j++) begin
      @(posedge sdclk);
      if (abort_busy && j == 3) begin
        do_reset();
        check("rst_bsy_oe", sddat_oe, 0);
        check("rst_bsy_busy", busy, 0);
        check("rst_bsy_err", crc_err, 0);
        return;
      end
      check("wr_busy_low", {sddat_oe, sddat_out}, 5'h1E);
    end
    @(posedge sdclk); check("wr_release", {sddat_oe, sddat_out}, 5'h1F);
    @(posedge sdclk); check("wr_oe_off", sddat_oe, 0);
    check("wr_done_once", done_cnt - d0, 1);
    check("wr_idle", busy, 0);
  endtask

  task automatic fill_wr(input bit inv);
    logic [7:0] v;
    for (int k = 0; k < 512; k++) begin
      v = 8'($urandom);
      wr_buf[k] = inv ? ~k[7:0] : v;
    end
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_oe", sddat_oe, 0);
    check("rst_out", sddat_out, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", crc_err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_we", mem_we, 0);
    check("rst_wdata", mem_wdata, 0);

    load(1'b1); read_block(-1, 1'b0);
    load(1'b0); read_block(-1, 1'b0);

    fill_wr(1'b1); write_block(-1, 4'hF, 1'b0, 1'b0);
    read_block(-1, 1'b0);
    fill_wr(1'b0); write_block(-1, 4'hF, 1'b0, 1'b0);
    fill_wr(1'b0); write_block(2, 4'hF, 1'b0, 1'b0);
    fill_wr(1'b0); write_block(-1, 4'h7, 1'b0, 1'b0);
    check("err_sticky_idle", crc_err, 1);

    load(1'b0); read_block(-1, 1'b1);

    fill_wr(1'b0); write_block(-1, 4'hF, 1'b1, 1'b0);
    repeat (3) @(posedge sdclk);
    check("rd_ignored_oe", sddat_oe, 0);
    check("rd_ignored_busy", busy, 0);
    read_block(-1, 1'b0);

    load(1'b0); read_block(300, 1'b0);
    read_block(-1, 1'b0);

    fill_wr(1'b0); write_block(-1, 4'hF, 1'b0, 1'b1);
    read_block(-1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
